text_write_ctrl: RTL

Cursor and write-address controller between the UART receiver and the 4x32 character text RAM that feeds the VGA text generator. It takes received bytes (one-cycle valid pulses) and turns them into RAM write requests. It handles printable characters, carriage return, backspace and form-feed clear. It also blanks the whole screen after reset, so the display never shows uninitialised RAM.

---
 rtl/text_write_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/text_write_ctrl.sv
// Turns received UART bytes into text-RAM writes and tracks the cursor; blanks the screen after reset or form feed.
// Latency 1 cycle from rx_valid to ram_we; bytes arriving during a clear sweep are dropped and flagged on overrun.
module text_write_ctrl #(
    parameter int COLS  = 32,
    parameter int ROWS  = 4,
    parameter int COL_W = 5,
    parameter int ROW_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             ram_we,
    output logic [ROW_W-1:0] ram_row,
    output logic [COL_W-1:0] ram_col,
    output logic [7:0]       ram_wdata,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic             busy,
    output logic             overrun
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [7:0]       BLANK    = 8'h20;

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t           state, state_n;
    logic [ROW_W-1:0] clr_row, clr_row_n;
    logic [COL_W-1:0] clr_col, clr_col_n;
    logic [ROW_W-1:0] cur_row_n;
    logic [COL_W-1:0] cur_col_n;
    logic             ram_we_n, busy_n, overrun_n;
    logic [ROW_W-1:0] ram_row_n;
    logic [COL_W-1:0] ram_col_n;
    logic [7:0]       ram_wdata_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR;
            clr_row    <= '0;
            clr_col    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            ram_we     <= 1'b0;
            ram_row    <= '0;
            ram_col    <= '0;
            ram_wdata  <= BLANK;
            busy       <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            clr_row    <= clr_row_n;
            clr_col    <= clr_col_n;
            cursor_row <= cur_row_n;
            cursor_col <= cur_col_n;
            ram_we     <= ram_we_n;
            ram_row    <= ram_row_n;
            ram_col    <= ram_col_n;
            ram_wdata  <= ram_wdata_n;
            busy       <= busy_n;
            overrun    <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        clr_row_n   = clr_row;
        clr_col_n   = clr_col;
        cur_row_n   = cursor_row;
        cur_col_n   = cursor_col;
        ram_we_n    = 1'b0;
        ram_row_n   = ram_row;
        ram_col_n   = ram_col;
        ram_wdata_n = ram_wdata;
        busy_n      = busy;
        overrun_n   = overrun;

        case (state)
            CLEAR: begin
                ram_we_n    = 1'b1;
                ram_row_n   = clr_row;
                ram_col_n   = clr_col;
                ram_wdata_n = BLANK;
                if (rx_valid)
                    overrun_n = 1'b1;
                if (clr_col == COL_LAST) begin
                    clr_col_n = '0;
                    if (clr_row == ROW_LAST) begin
                        clr_row_n = '0;
                        state_n   = IDLE;
                        busy_n    = 1'b0;
                        cur_row_n = '0;
                        cur_col_n = '0;
                    end else begin
                        clr_row_n = clr_row + ROW_W'(1);
                    end
                end else begin
                    clr_col_n = clr_col + COL_W'(1);
                end
            end

            IDLE: begin
                if (rx_valid) begin
                    if (rx_data >= 8'h20 && rx_data <= 8'h7E) begin
                        ram_we_n    = 1'b1;
                        ram_row_n   = cursor_row;
                        ram_col_n   = cursor_col;
                        ram_wdata_n = rx_data;
                        if (cursor_col == COL_LAST) begin
                            cur_col_n = '0;
                            cur_row_n = (cursor_row == ROW_LAST) ? '0 : cursor_row + ROW_W'(1);
                        end else begin
                            cur_col_n = cursor_col + COL_W'(1);
                        end
                    end else if (rx_data == 8'h0D) begin
                        cur_col_n = '0;
                        cur_row_n = (cursor_row == ROW_LAST) ? '0 : cursor_row + ROW_W'(1);
                    end else if (rx_data == 8'h08) begin
                        if (cursor_col != '0) begin
                            cur_col_n   = cursor_col - COL_W'(1);
                            ram_we_n    = 1'b1;
                            ram_row_n   = cursor_row;
                            ram_col_n   = cursor_col - COL_W'(1);
                            ram_wdata_n = BLANK;
                        end else if (cursor_row != '0) begin
                            cur_row_n   = cursor_row - ROW_W'(1);
                            cur_col_n   = COL_LAST;
                            ram_we_n    = 1'b1;
                            ram_row_n   = cursor_row - ROW_W'(1);
                            ram_col_n   = COL_LAST;
                            ram_wdata_n = BLANK;
                        end
                    end else if (rx_data == 8'h0C) begin
                        // First blank goes out with the form-feed response; the sweep resumes at the second cell.
                        state_n     = CLEAR;
                        busy_n      = 1'b1;
                        ram_we_n    = 1'b1;
                        ram_row_n   = '0;
                        ram_col_n   = '0;
                        ram_wdata_n = BLANK;
                        if (COLS > 1) begin
                            clr_row_n = '0;
                            clr_col_n = COL_W'(1);
                        end else begin
                            clr_row_n = ROW_W'(1);
                            clr_col_n = '0;
                        end
                    end
                end
            end

            default: state_n = CLEAR;
        endcase
    end

endmodule
